if_fetch_stage: RTL and testbench

//  Instruction-fetch stage feeding the decode/control stage (CTRL, RF, EXTEND).

---
 rtl/if_fetch_stage.sv | 160 ++++++++++++++++
 tb/tb_if_fetch_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_stage
// Purpose  : Instruction fetch with a 1-cycle synchronous-read imem and a small
//            PC/instruction FIFO handed to decode over valid/ready.
//            Define IF_PERF_CNT_EN to add fetch/bubble performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ADDR_W    = 9,
  parameter int          BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_i,
  input  logic [31:0]       redirect_pc_i,
  output logic              imem_en_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [31:0]       imem_rdata_i,
  output logic              id_valid_o,
  input  logic              id_ready_i,
  output logic [31:0]       id_inst_o,
  output logic [31:0]       id_pc_o,
  output logic [31:0]       id_pc_4_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt_o,
  output logic [31:0]       perf_bubble_cnt_o
`endif
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] c_full      = CNT_W'(BUF_DEPTH);
  localparam logic [OCC_W-1:0] c_depth_occ = OCC_W'(BUF_DEPTH);
  localparam logic [31:0]      c_pc_mask   = 32'hFFFF_FFFC;

  logic [31:0]      fpc_q, fpc_d;
  logic             inflight_q, inflight_d;
  logic [31:0]      inf_pc_q, inf_pc_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      buf_inst_q [BUF_DEPTH];
  logic [31:0]      buf_pc_q   [BUF_DEPTH];

  logic             w_valid;
  logic             w_pop;
  logic             w_push;
  logic             w_issue;
  logic [OCC_W-1:0] w_occ;

  assign w_valid = (count_q != '0);
  assign w_pop   = w_valid & id_ready_i & ~redirect_i;
  assign w_push  = inflight_q & ~redirect_i;

  // Credit check: entries held + response on its way - entry leaving now must
  // leave room for the word this request will return next cycle.
  assign w_occ   = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(w_pop);
  assign w_issue = rst_n & ~redirect_i & (w_occ < c_depth_occ);

  always_comb begin
    fpc_d      = fpc_q;
    inflight_d = inflight_q;
    inf_pc_d   = inf_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (redirect_i) begin
      fpc_d      = redirect_pc_i & c_pc_mask;
      inflight_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      inflight_d = w_issue;
      if (w_issue) begin
        fpc_d    = fpc_q + 32'd4;
        inf_pc_d = fpc_q;
      end
      if (w_push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc_q      <= RESET_PC;
      inflight_q <= 1'b0;
      inf_pc_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fpc_q      <= fpc_d;
      inflight_q <= inflight_d;
      inf_pc_q   <= inf_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: nothing is visible unless count_q says so.
  always_ff @(posedge clk) begin
    if (w_push) begin
      buf_inst_q[wr_ptr_q] <= imem_rdata_i;
      buf_pc_q[wr_ptr_q]   <= inf_pc_q;
    end
  end

  assign imem_en_o   = w_issue;
  assign imem_addr_o = fpc_q[ADDR_W+1:2];
  assign id_valid_o  = w_valid;
  assign id_inst_o   = w_valid ? buf_inst_q[rd_ptr_q] : 32'd0;
  assign id_pc_o     = w_valid ? buf_pc_q[rd_ptr_q]   : 32'd0;
  assign id_pc_4_o   = w_valid ? (buf_pc_q[rd_ptr_q] + 32'd4) : 32'd0;

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_bubble_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_q  <= '0;
      perf_bubble_q <= '0;
    end else begin
      if (w_pop) begin
        perf_fetch_q <= perf_fetch_q + 32'd1;
      end
      if (id_ready_i && !w_valid) begin
        perf_bubble_q <= perf_bubble_q + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt_o  = perf_fetch_q;
  assign perf_bubble_cnt_o = perf_bubble_q;
`else
  // Counters compiled out; the fetch path is unchanged.
`endif

`ifndef SYNTHESIS
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && !w_pop && (count_q == c_full)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_stage
// Purpose  : Self-checking bench for if_fetch_stage against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_stage;

  localparam int          DEPTH   = 2;
  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] RST_PCW = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        id_ready = 1'b0;
  logic        imem_en;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rdata = 32'd0;
  logic        id_valid;
  logic [31:0] id_inst, id_pc, id_pc_4;

  logic        w_redirect = 1'b0;
  logic [31:0] w_redirect_pc = 32'd0;
  logic        w_ready = 1'b1;
  logic        w_imem_en;
  logic [8:0]  w_imem_addr;
  logic [31:0] w_imem_rdata = 32'd0;
  logic        w_valid;
  logic [31:0] w_inst, w_pc, w_pc_4;

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch, perf_bubble, w_perf_fetch, w_perf_bubble;
`endif

  always #5 clk = ~clk;

  if_fetch_stage #(.RESET_PC(RST_PC), .ADDR_W(9), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_en_o(imem_en), .imem_addr_o(imem_addr), .imem_rdata_i(imem_rdata),
    .id_valid_o(id_valid), .id_ready_i(id_ready),
    .id_inst_o(id_inst), .id_pc_o(id_pc), .id_pc_4_o(id_pc_4)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch_cnt_o(perf_fetch), .perf_bubble_cnt_o(perf_bubble)
`endif
  );

  if_fetch_stage #(.RESET_PC(RST_PCW), .ADDR_W(9), .BUF_DEPTH(DEPTH)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .redirect_i(w_redirect), .redirect_pc_i(w_redirect_pc),
    .imem_en_o(w_imem_en), .imem_addr_o(w_imem_addr), .imem_rdata_i(w_imem_rdata),
    .id_valid_o(w_valid), .id_ready_i(w_ready),
    .id_inst_o(w_inst), .id_pc_o(w_pc), .id_pc_4_o(w_pc_4)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch_cnt_o(w_perf_fetch), .perf_bubble_cnt_o(w_perf_bubble)
`endif
  );

  function automatic logic [31:0] word(input logic [8:0] a);
    return {7'h2D, a, ~a, 7'h11};
  endfunction

  // Synchronous-read instruction memories
  always @(posedge clk) begin
    if (imem_en)   imem_rdata   <= word(imem_addr);
    if (w_imem_en) w_imem_rdata <= word(w_imem_addr);
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: fetch PC, one optional outstanding request, queue of delivered PCs
  logic [31:0] m_fpc;
  logic        m_inf;
  logic [31:0] m_inf_pc;
  logic [31:0] m_q[$];
  logic [31:0] m_pops, m_bub;
  bit          w_chk = 1'b0;
  int          w_idx = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fpc    = RST_PC;
    m_inf    = 1'b0;
    m_inf_pc = 32'd0;
    m_q.delete();
    m_pops   = 32'd0;
    m_bub    = 32'd0;
  endtask

  task automatic cycle();
    bit          e_valid, e_pop, e_en, s_rdy, s_redir, s_rst;
    logic [31:0] s_tgt, hpc;
    int          occ;
    @(negedge clk);
    if (!rst_n) model_reset();
    s_rdy   = id_ready;
    s_redir = redirect;
    s_rst   = rst_n;
    s_tgt   = redirect_pc;
    e_valid = (m_q.size() != 0);
    e_pop   = e_valid && s_rdy && !s_redir;
    occ     = m_q.size() + int'(m_inf) - int'(e_pop);
    e_en    = s_rst && !s_redir && (occ < DEPTH);
    hpc     = e_valid ? m_q[0] : 32'd0;
    check("id_valid", {31'd0, id_valid}, {31'd0, e_valid});
    check("imem_en", {31'd0, imem_en}, {31'd0, e_en});
    if (e_en) check("imem_addr", {23'd0, imem_addr}, {23'd0, m_fpc[10:2]});
    check("id_pc", id_pc, hpc);
    check("id_inst", id_inst, e_valid ? word(hpc[10:2]) : 32'd0);
    check("id_pc_4", id_pc_4, e_valid ? hpc + 32'd4 : 32'd0);
`ifdef IF_PERF_CNT_EN
    check("perf_fetch", perf_fetch, m_pops);
    check("perf_bubble", perf_bubble, m_bub);
`endif
    if (w_chk && w_idx >= 2 && w_idx <= 4) begin
      check("wrap_valid", {31'd0, w_valid}, 32'd1);
      check("wrap_pc", w_pc, RST_PCW + 32'(4 * (w_idx - 2)));
      check("wrap_pc_4", w_pc_4, RST_PCW + 32'(4 * (w_idx - 1)));
    end
    @(posedge clk);
    if (s_rst) begin
      if (s_rdy && !e_valid) m_bub++;
      if (e_pop) m_pops++;
      if (s_redir) begin
        m_q.delete();
        m_inf = 1'b0;
        m_fpc = s_tgt & 32'hFFFF_FFFC;
      end else begin
        if (e_pop) void'(m_q.pop_front());
        if (m_inf) m_q.push_back(m_inf_pc);
        m_inf = e_en;
        if (e_en) begin
          m_inf_pc = m_fpc;
          m_fpc    = m_fpc + 32'd4;
        end
      end
      if (m_q.size() > DEPTH) check("model_depth", 32'(m_q.size()), DEPTH);
    end
    w_idx++;
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    model_reset();
    id_ready = 1'b1;
    cycle();
    cycle();
    // Reset release: in-order stream from RESET_PC, wrap instance checked alongside
    rst_n = 1'b1;
    w_chk = 1'b1;
    w_idx = 0;
    for (int i = 0; i < 8; i++) cycle();
    w_chk = 1'b0;
    // Backpressure: decode stalls, FIFO fills, fetch stops, then drains
    id_ready = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    id_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    // Redirect while buffer holds data and a fetch is in flight
    id_ready = 1'b0;
    cycle();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    cycle();
    redirect = 1'b0;
    id_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    // Back-to-back redirects: only the last target is fetched
    redirect = 1'b1;
    redirect_pc = 32'h0000_0040;
    cycle();
    redirect_pc = 32'h0000_0080;
    cycle();
    redirect = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      id_ready = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 2))
        0:       redirect_pc = $urandom;
        1:       redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: redirect_pc = 32'($urandom_range(0, 2047));
      endcase
      cycle();
    end
    redirect = 1'b0;
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    // Asynchronous reset mid-stream
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, id_valid}, 32'd0);
    check("async_rst_en", {31'd0, imem_en}, 32'd0);
    model_reset();
    cycle();
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) cycle();
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    id_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
